irq_ctrl: RTL and testbench

Interrupt controller that sits between the interrupt sources (timer, external interrupt generator, future peripherals) and the pipeline CPU. It latches source requests into a pending register, filters them through a software-writable mask, and selects one winner by fixed priority or round-robin. It drives a single request/ID to the CPU and returns a one-cycle acknowledge to the winning source. It then holds off further requests until the CPU signals end of service.

---
 rtl/irq_ctrl_if.sv | 31 +++
 rtl/irq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bundles the interrupt controller's source, CPU and config signals.
//   src_int/src_ack  : level requests in, one-hot one-cycle acknowledge out
//   irq_req/irq_id   : request and source index to the CPU
//   irq_ack/irq_done : CPU trap-taken and end-of-service pulses
//   cfg_*            : register write strobe/address/data, combinational read data
// The slave modport is the controller; master is the environment (sources, CPU, config).
interface irq_ctrl_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_SRC-1:0] src_int;
  logic [NUM_SRC-1:0] src_ack;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ack;
  logic               irq_done;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;

  modport slave (
    input  src_int, irq_ack, irq_done, cfg_we, cfg_addr, cfg_wdata,
    output src_ack, irq_req, irq_id, cfg_rdata
  );

  modport master (
    output src_int, irq_ack, irq_done, cfg_we, cfg_addr, cfg_wdata,
    input  src_ack, irq_req, irq_id, cfg_rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches source edges into a pending register, filters by mask,
// picks one winner (fixed priority or round-robin) and runs a single
// request/acknowledge/service handshake with the CPU.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : irq_ctrl_if.slave (src_int/src_ack, irq_req/irq_id, irq_ack/irq_done, cfg_*)
// Registers: 0 MASK (rw), 1 PENDING (W1C), 2 MODE (bit0 rw), 3 STATUS (ro).
module irq_ctrl #(
  parameter int unsigned        NUM_SRC  = 4,
  parameter int unsigned        ID_W     = 3,
  parameter logic [NUM_SRC-1:0] MASK_RST = '1
) (
  input  logic      clk,
  input  logic      reset,
  irq_ctrl_if.slave bus
);

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_ack_q, src_ack_d;
  logic               mode_q, mode_d;
  logic               irq_req_q, irq_req_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] cur_onehot;
  logic               cur_elig;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        rdata;
  logic               unused_wdata;

  assign eligible   = pend_q & mask_q;
  assign rise       = bus.src_int & ~src_q;
  assign cur_onehot = NUM_SRC'(1) << irq_id_q;
  assign cur_elig   = |(eligible & cur_onehot);

  // Only the low NUM_SRC write-data bits carry register content.
  assign unused_wdata = ^bus.cfg_wdata[31:NUM_SRC];

  // Config writes: mask/mode update, W1C strobe for pending.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    w1c    = '0;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_MASK: mask_d = bus.cfg_wdata[NUM_SRC-1:0];
        ADDR_PEND: w1c    = bus.cfg_wdata[NUM_SRC-1:0];
        ADDR_MODE: mode_d = bus.cfg_wdata[0];
        default:   ;
      endcase
    end
  end

  // A new edge outranks any clear landing in the same cycle.
  assign pend_d = (pend_q & ~(w1c | ack_clr)) | rise;

  // Winner search: rotate the start point past last_id in round-robin mode.
  always_comb begin
    int unsigned start_idx;
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    start_idx = mode_q ? ((32'(last_id_q) + 32'd1) % NUM_SRC) : 32'd0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (start_idx + k) % NUM_SRC;
      if (!win_found && (|(eligible & (NUM_SRC'(1) << idx)))) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Request FSM: next state and registered-output next values.
  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    last_id_d = last_id_q;
    src_ack_d = '0;
    ack_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_REQ;
          irq_id_d = win_id;
        end
      end
      ST_REQ: begin
        // Ack beats a simultaneous withdrawal.
        if (bus.irq_ack) begin
          state_d   = ST_SERVICE;
          src_ack_d = cur_onehot;
          ack_clr   = cur_onehot;
          last_id_d = irq_id_q;
        end else if (!cur_elig) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.irq_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      mask_q    <= MASK_RST;
      mode_q    <= 1'b0;
      src_q     <= '0;
      src_ack_q <= '0;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      last_id_q <= ID_W'(NUM_SRC - 1);
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      src_q     <= bus.src_int;
      src_ack_q <= src_ack_d;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
      last_id_q <= last_id_d;
    end
  end

  // Register read mux; STATUS packs state in [1:0] and irq_id in [8:2].
  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      ADDR_MASK:   rdata = 32'(mask_q);
      ADDR_PEND:   rdata = 32'(pend_q);
      ADDR_MODE:   rdata = 32'(mode_q);
      ADDR_STATUS: begin
        rdata[1:0] = state_q;
        rdata[8:2] = 7'(irq_id_q);
      end
      default:     rdata = '0;
    endcase
  end

  assign bus.cfg_rdata = rdata;
  assign bus.src_ack   = src_ack_q;
  assign bus.irq_req   = irq_req_q;
  assign bus.irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed stimulus for irq_ctrl with a queue-based scoreboard.
// Stimulus pushes the expected irq_id / src_ack before each event; a monitor
// on the falling edge pops and compares on every irq_req rise and src_ack pulse.
module tb_irq_ctrl;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_W    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

  irq_ctrl #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .MASK_RST(4'hF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int         exp_id_q[$];
  logic [3:0] exp_ack_q[$];
  logic       prev_req = 1'b0;

  int rr_order[4]  = '{0, 1, 2, 0};
  int fix_order[4] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.src_ack != '0) begin
        if (exp_ack_q.size() == 0) check("src_ack_unexpected", 32'(bus.src_ack), 32'd0);
        else                       check("src_ack", 32'(bus.src_ack), 32'(exp_ack_q.pop_front()));
      end
      if (bus.irq_req && !prev_req) begin
        if (exp_id_q.size() == 0) check("irq_req_unexpected", 32'(bus.irq_req), 32'd0);
        else                      check("irq_id", 32'(bus.irq_id), 32'(exp_id_q.pop_front()));
      end
    end
    prev_req <= bus.irq_req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick(1);
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!bus.irq_req && n < budget) begin
      tick(1);
      n++;
    end
    if (!bus.irq_req) check("irq_req_timeout", 32'(bus.irq_req), 32'd1);
  endtask

  // Acknowledge the pending request from source id, then the source drops its line.
  task automatic serve(input int id);
    wait_req(20);
    exp_ack_q.push_back(4'(1 << id));
    bus.irq_ack = 1'b1;
    tick(1);
    bus.irq_ack = 1'b0;
    bus.src_int[id] = 1'b0;
  endtask

  task automatic done_pulse();
    bus.irq_done = 1'b1;
    tick(1);
    bus.irq_done = 1'b0;
  endtask

  // Sources 0..2 all pending; each served source re-asserts before end of service.
  task automatic run_order(input int order[4], input int n);
    exp_id_q.push_back(order[0]);
    bus.src_int = 4'b0111;
    for (int k = 0; k < n; k++) begin
      serve(order[k]);
      if (k < n - 1) begin
        tick(1);
        bus.src_int[order[k]] = 1'b1;
        tick(3);
        exp_id_q.push_back(order[k+1]);
      end else begin
        bus.src_int = '0;
        cfg_write(2'd1, 32'hF);
      end
      done_pulse();
    end
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bus.src_int   = '0;
    bus.irq_ack   = 1'b0;
    bus.irq_done  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;

    // Reset values
    tick(2);
    check("rst_irq_req", 32'(bus.irq_req), 32'd0);
    check("rst_irq_id", 32'(bus.irq_id), 32'd0);
    check("rst_src_ack", 32'(bus.src_ack), 32'd0);
    cfg_read(2'd0, d); check("rst_mask", d, 32'hF);
    cfg_read(2'd1, d); check("rst_pend", d, 32'h0);
    cfg_read(2'd2, d); check("rst_mode", d, 32'h0);
    cfg_read(2'd3, d); check("rst_status", d, 32'h0);
    reset = 1'b0;
    tick(8);

    // Single source: 2-cycle latency, ack pulse, end of service
    exp_id_q.push_back(1);
    bus.src_int[1] = 1'b1;
    tick(1);
    check("lat1_req_low", 32'(bus.irq_req), 32'd0);
    cfg_read(2'd1, d); check("lat1_pend", d, 32'h2);
    tick(1);
    check("lat2_req", 32'(bus.irq_req), 32'd1);
    tick(2);
    check("req_held", 32'(bus.irq_req), 32'd1);
    exp_ack_q.push_back(4'b0010);
    bus.irq_ack = 1'b1;
    tick(1);
    bus.irq_ack = 1'b0;
    bus.src_int[1] = 1'b0;
    check("ack_req_low", 32'(bus.irq_req), 32'd0);
    check("ack_src_ack", 32'(bus.src_ack), 32'h2);
    cfg_read(2'd1, d); check("ack_pend_clr", d, 32'h0);
    tick(1);
    check("ack_one_cycle", 32'(bus.src_ack), 32'd0);
    cfg_read(2'd3, d); check("status_service", d, 32'h6);
    done_pulse();
    cfg_read(2'd3, d); check("status_idle", d, 32'h4);
    tick(3);
    check("idle_no_req", 32'(bus.irq_req), 32'd0);

    // Fixed priority: 0 beats 3, then 3
    exp_id_q.push_back(0);
    bus.src_int = 4'b1001;
    serve(0);
    tick(2);
    exp_id_q.push_back(3);
    done_pulse();
    serve(3);
    tick(2);
    done_pulse();
    tick(3);

    // Round-robin 0,1,2,0 then fixed 0,0,0
    cfg_write(2'd2, 32'h1);
    run_order(rr_order, 4);
    cfg_read(2'd3, d); check("rr_end_idle", 32'(d[1:0]), 32'd0);
    cfg_write(2'd2, 32'h0);
    run_order(fix_order, 3);

    // Mask withdraw and re-issue
    exp_id_q.push_back(2);
    bus.src_int[2] = 1'b1;
    wait_req(10);
    cfg_write(2'd0, 32'hB);
    check("withdraw_not_yet", 32'(bus.irq_req), 32'd1);
    cfg_read(2'd0, d); check("mask_read", d, 32'hB);
    tick(1);
    check("withdraw_req_low", 32'(bus.irq_req), 32'd0);
    tick(2);
    cfg_read(2'd3, d); check("withdraw_idle", 32'(d[1:0]), 32'd0);
    exp_id_q.push_back(2);
    cfg_write(2'd0, 32'hF);
    tick(1);
    check("reissue_req", 32'(bus.irq_req), 32'd1);
    serve(2);
    tick(1);
    done_pulse();
    tick(2);

    // Set/clear collision, then request held across SERVICE
    exp_id_q.push_back(1);
    bus.src_int[1] = 1'b1;
    cfg_write(2'd1, 32'h2);
    cfg_read(2'd1, d); check("collision_set_wins", d, 32'h2);
    serve(1);
    bus.src_int[3] = 1'b1;
    tick(4);
    check("svc_no_req", 32'(bus.irq_req), 32'd0);
    cfg_read(2'd1, d); check("svc_pend_accum", d, 32'h8);
    exp_id_q.push_back(3);
    done_pulse();
    check("release_t0", 32'(bus.irq_req), 32'd0);
    tick(1);
    check("release_t1", 32'(bus.irq_req), 32'd1);
    serve(3);
    tick(1);
    done_pulse();
    tick(2);

    // Reset while in SERVICE
    cfg_write(2'd0, 32'h3);
    cfg_write(2'd2, 32'h1);
    exp_id_q.push_back(0);
    bus.src_int[0] = 1'b1;
    serve(0);
    bus.src_int[2] = 1'b1;
    tick(2);
    reset = 1'b1;
    bus.src_int = '0;
    tick(1);
    reset = 1'b0;
    check("rst2_irq_req", 32'(bus.irq_req), 32'd0);
    check("rst2_irq_id", 32'(bus.irq_id), 32'd0);
    check("rst2_src_ack", 32'(bus.src_ack), 32'd0);
    cfg_read(2'd0, d); check("rst2_mask", d, 32'hF);
    cfg_read(2'd1, d); check("rst2_pend", d, 32'h0);
    cfg_read(2'd2, d); check("rst2_mode", d, 32'h0);
    cfg_read(2'd3, d); check("rst2_status", d, 32'h0);
    bus.irq_ack = 1'b1;
    tick(1);
    bus.irq_ack = 1'b0;
    bus.irq_done = 1'b1;
    tick(1);
    bus.irq_done = 1'b0;
    tick(3);
    check("spurious_no_req", 32'(bus.irq_req), 32'd0);
    cfg_read(2'd3, d); check("spurious_idle", d, 32'h0);

    // last_id back at NUM_SRC-1: round-robin starts at source 0
    cfg_write(2'd2, 32'h1);
    exp_id_q.push_back(0);
    bus.src_int = 4'b1011;
    serve(0);
    bus.src_int = '0;
    cfg_write(2'd1, 32'hF);
    done_pulse();
    tick(5);

    check("exp_id_left", 32'(exp_id_q.size()), 32'd0);
    check("exp_ack_left", 32'(exp_ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
